// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-group predicates for the
// sequential ALU / multiply-divide execute unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b00110;
  localparam logic [4:0] OP_OR     = 5'b00111;
  localparam logic [4:0] OP_AND    = 5'b01000;
  localparam logic [4:0] OP_SUB    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return is_m_op(op) && op[2];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide datapath on unsigned magnitudes.
// One shift-add or restoring-subtract step per step pulse; sign fix is combinational.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [4:0]      op_q;
  logic            sa_q, sb_q, bz_q;
  logic [XLEN-1:0] a_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic            sa, sb;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   mul_sum, div_trial, div_diff;
  logic            div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    sa   = rs1[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                           op == OP_DIV || op == OP_REM);
    sb   = rs2[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
    mag1 = sa ? -rs1 : rs1;
    mag2 = sb ? -rs2 : rs2;
  end

  // hi holds the partial product / partial remainder, lo the multiplier / dividend-quotient
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, a_q};
    div_ge    = !div_diff[XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      bz_q  <= 1'b0;
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      op_q  <= op;
      sa_q  <= sa;
      sb_q  <= sb;
      bz_q  <= (rs2 == '0);
      a_q   <= mag2;
      hi_q  <= '0;
      lo_q  <= mag1;
      cnt_q <= CNT_W'(XLEN);
    end else if (step) begin
      if (is_div_op(op_q)) begin
        hi_q <= div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], div_ge};
      end else begin
        {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
      end
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

  // Divide by zero keeps the all-ones quotient; remainder sign always follows the dividend
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
    rem_fix  = sa_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                        result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = bz_q ? '1 : quo_fix;
      OP_REM, OP_REMU:               result = rem_fix;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// XLEN-wide execute unit: single-cycle base ALU plus optional iterative
// RV32M multiply/divide, with a registered valid/ready result.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  bit ENABLE_M = 1'b1,
  localparam int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  state_e          state_q, state_d;
  logic            accept, m_ok, mdu_start, mdu_last;
  logic [XLEN-1:0] mdu_res;

  function automatic logic [XLEN-1:0] base_alu(input logic [4:0] f,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHAMT_W-1:0]     sh;
    a_s = a;
    b_s = b;
    sh  = b[SHAMT_W-1:0];
    case (f)
      OP_ADD:  return a + b;
      OP_SLL:  return a << sh;
      OP_SLT:  return {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> sh;
      OP_SRA:  return a_s >>> sh;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  assign m_ok      = ENABLE_M && is_m_op(op);
  assign accept    = in_valid && in_ready;
  assign mdu_start = accept && m_ok;

  if (ENABLE_M) begin : g_mdu
    mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdu_start),
      .step   (state_q == ITER),
      .op     (op),
      .rs1    (rs1),
      .rs2    (rs2),
      .last   (mdu_last),
      .result (mdu_res)
    );
  end else begin : g_no_mdu
    assign mdu_last = 1'b0;
    assign mdu_res  = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    in_ready = rst_n && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
    case (state_q)
      IDLE:    if (mdu_start) state_d = ITER;
      ITER:    if (mdu_last)  state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output register: base results land one edge after accept, M results on the FIX edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !m_ok) begin
        out       <= base_alu(op, rs1, rs2);
        out_valid <= 1'b1;
      end else if (state_q == FIX) begin
        out       <= mdu_res;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq with a result scoreboard queue.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid0 = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;

  logic        in_ready, out_valid, busy;
  logic [31:0] out;
  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  alu_mdu_seq #(.XLEN(32), .ENABLE_M(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid0), .out_ready(out_ready),
    .out(out0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transferred result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", out);
      end
      if (sbq.size() > 0) check("sb_out", out, sbq.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit push);
    int n;
    op = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", in_ready, 1'b1);
    if (push) sbq.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n, output bit busy_ok, output logic busy_end);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && !busy) busy_ok = 1'b0;
    end while (!out_valid && n < 100);
    busy_end = busy;
    @(posedge clk); #1;
  endtask

  task automatic mop(input string tag, input logic [4:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int   n;
    bit   bok;
    logic bend;
    send(f, a, b, exp, 1'b1);
    wait_result(n, bok, bend);
    check({tag, "_lat"}, n, 34);
    check({tag, "_busy"}, bok, 1'b1);
    check({tag, "_busy_end"}, bend, 1'b0);
  endtask

  logic [4:0]  bop [11] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SLL, OP_SRL,
                            5'b01111, OP_OR, OP_AND, OP_XOR};
  logic [31:0] ba  [11] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1,
                            32'h80000000, 32'd12, 32'h000000F0, 32'h0000FF00, 32'h000000A5};
  logic [31:0] bb  [11] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'd4, 32'h0000003F,
                            32'd4, 32'd34, 32'h0000000F, 32'h00000FF0, 32'h000000FF};
  logic [31:0] bx  [11] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h80000000,
                            32'h08000000, 32'd0, 32'h000000FF, 32'h00000F00, 32'h0000005A};

  initial begin
    int   n;
    bit   bok, seen;
    logic bend;

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Base ops back to back
    for (int i = 0; i < 11; i++) begin
      op = bop[i]; rs1 = ba[i]; rs2 = bb[i]; in_valid = 1'b1;
      @(negedge clk);
      check("b2b_rdy", in_ready, 1'b1);
      if (i > 0) check("base_lat", out_valid, 1'b1);
      sbq.push_back(bx[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("base_lat", out_valid, 1'b1);
    @(posedge clk); #1;

    // Multiply
    mop("mulh",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    mop("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    mop("mul",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    mop("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
    mop("mul2",   OP_MUL,    32'd12345,    32'd678,      32'd8369910);

    // Divide
    mop("div",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    mop("rem",    OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    mop("divu0",  OP_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF);
    mop("remu0",  OP_REMU, 32'd7,        32'd0,        32'd7);
    mop("divov",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    mop("remov",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0);
    mop("div0s",  OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
    mop("rem0s",  OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
    mop("divu",   OP_DIVU, 32'd100,      32'd7,        32'd14);
    mop("remu",   OP_REMU, 32'd100,      32'd7,        32'd2);

    // Backpressure
    out_ready = 1'b0;
    send(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1);
    op = OP_ADD; rs1 = 32'd10; rs2 = 32'd20; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_out", out, 32'd5);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_accept", in_ready, 1'b1);
    sbq.push_back(32'd30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Flush mid-divide
    send(OP_DIV, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    op = OP_ADD; in_valid = 1'b1;
    @(negedge clk);
    check("flush_busy_before", busy, 1'b1);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);
    @(posedge clk); #1;
    send(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b1);
    wait_result(n, bok, bend);
    check("add_after_flush_lat", n, 1);

    // Asynchronous reset mid-iteration
    send(OP_MUL, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out", out, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("arst_no_result", seen, 1'b0);
    @(posedge clk); #1;

    // Build without the M extension
    op = OP_MUL; rs1 = 32'd3; rs2 = 32'd4; in_valid0 = 1'b1;
    @(negedge clk);
    check("nom_in_ready", in_ready0, 1'b1);
    @(posedge clk); #1;
    op = OP_ADD;
    @(negedge clk);
    check("nom_mul_valid", out_valid0, 1'b1);
    check("nom_mul_out", out0, 32'd0);
    check("nom_busy", busy0, 1'b0);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    check("nom_add_valid", out_valid0, 1'b1);
    check("nom_add_out", out0, 32'd7);
    @(posedge clk); #1;

    check("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
